// File: rtl/apb_master_q.sv
// apb_master_q: queued APB master. System-side requests are buffered in a
// FIFO of FIFO_DEPTH entries and issued back-to-back as SETUP/ACCESS
// transfers; every completion produces a one-cycle rsp_valid pulse with
// status OK, slave error or timeout.
// Optional feature: define APB_MASTER_Q_TIMEOUT_EN to compile in the
// ACCESS wait counter and the timeout abort (rsp_err = 2'b10).
module apb_master_q #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          apb_clk,
    input  logic                          apb_reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    input  logic                          req_write,
    output logic                          rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic [1:0]                    rsp_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          apb_selx,
    output logic                          apb_en,
    output logic                          apb_write,
    output logic [ADDR_W-1:0]             apb_addr,
    output logic [DATA_W-1:0]             apb_wdata,
    input  logic [DATA_W-1:0]             apb_rdata,
    input  logic                          apb_ready,
    input  logic                          apb_slverr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // Illegal parameter sets elaborate this marker scope so they show up in
    // the elaborated hierarchy instead of silently misbehaving.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_params
    end

`ifdef APB_MASTER_Q_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] WAIT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
`endif

    // ---------------------------------------------------------------- FIFO
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             full, empty, push, pop;
    logic [ENT_W-1:0] head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic              head_write;

    assign full  = (lvl_q == LVL_FULL);
    assign empty = (lvl_q == '0);
    // A push while full is dropped even if the FSM pops in the same cycle.
    assign push  = req_valid && !full;
    assign head  = mem_q[rd_ptr_q];
    assign {head_addr, head_wdata, head_write} = head;

    // FIFO occupancy update from push/pop.
    always_comb begin
        lvl_d = lvl_q;
        if (push && !pop) begin
            lvl_d = lvl_q + LVL_ONE;
        end else if (!push && pop) begin
            lvl_d = lvl_q - LVL_ONE;
        end
    end

    // FIFO pointers and level; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge apb_clk or negedge apb_reset) begin
        if (!apb_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            lvl_q <= lvl_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate validity.
    always_ff @(posedge apb_clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_addr, req_wdata, req_write};
    end

    // ----------------------------------------------------------------- FSM
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              slverr_q, slverr_d;
`ifdef APB_MASTER_Q_TIMEOUT_EN
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
`endif

    // Transfer sequencing, head pop and completion capture.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        slverr_d    = slverr_q;
        pop         = 1'b0;
`ifdef APB_MASTER_Q_TIMEOUT_EN
        timeout_d   = timeout_q;
        wait_d      = wait_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    addr_d  = head_addr;
                    wdata_d = head_wdata;
                    write_d = head_write;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_MASTER_Q_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            ST_ACCESS: begin
                // Ready is tested before the timeout so a same-edge ready wins.
                if (apb_ready) begin
                    rsp_valid_d = 1'b1;
                    slverr_d    = apb_slverr;
                    rdata_d     = (!write_q && !apb_slverr) ? apb_rdata : '0;
`ifdef APB_MASTER_Q_TIMEOUT_EN
                    timeout_d   = 1'b0;
`endif
                    if (!empty) begin
                        pop     = 1'b1;
                        addr_d  = head_addr;
                        wdata_d = head_wdata;
                        write_d = head_write;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef APB_MASTER_Q_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    rsp_valid_d = 1'b1;
                    slverr_d    = 1'b0;
                    timeout_d   = 1'b1;
                    rdata_d     = '0;
                    state_d     = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, transfer and response registers.
    always_ff @(posedge apb_clk or negedge apb_reset) begin
        if (!apb_reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            slverr_q    <= 1'b0;
`ifdef APB_MASTER_Q_TIMEOUT_EN
            timeout_q   <= 1'b0;
            wait_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            slverr_q    <= slverr_d;
`ifdef APB_MASTER_Q_TIMEOUT_EN
            timeout_q   <= timeout_d;
            wait_q      <= wait_d;
`endif
        end
    end

    // ------------------------------------------------------------- outputs
    // APB outputs are decoded from state so they are all 0 in IDLE and
    // drop immediately on asynchronous reset.
    assign apb_selx  = (state_q != ST_IDLE);
    assign apb_en    = (state_q == ST_ACCESS);
    assign apb_write = apb_selx && write_q;
    assign apb_addr  = apb_selx ? addr_q  : '0;
    assign apb_wdata = apb_selx ? wdata_q : '0;

    assign req_ready  = !full;
    assign fifo_level = lvl_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
`ifdef APB_MASTER_Q_TIMEOUT_EN
    assign rsp_err    = {timeout_q, slverr_q};
`else
    assign rsp_err    = {1'b0, slverr_q};
`endif

endmodule

// File: tb/tb_apb_master_q.sv
// tb_apb_master_q: scoreboard bench for apb_master_q with a small APB
// slave model (zero-wait by default, error at addr 100, never-ready at
// addr 1 when enabled, ready only in the 16th ACCESS cycle at addr 2).
`timescale 1ns/1ps
module tb_apb_master_q;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 16;
    localparam int CLK_P      = 10;

    logic              apb_clk = 1'b0;
    logic              apb_reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_write;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_err;
    logic [2:0]        fifo_level;
    logic              apb_selx, apb_en, apb_write;
    logic [ADDR_W-1:0] apb_addr;
    logic [DATA_W-1:0] apb_wdata;
    logic [DATA_W-1:0] apb_rdata;
    logic              apb_ready;
    logic              apb_slverr;

    always #(CLK_P/2) apb_clk = ~apb_clk;

    apb_master_q #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .apb_clk(apb_clk), .apb_reset(apb_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_write(req_write),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .fifo_level(fifo_level),
        .apb_selx(apb_selx), .apb_en(apb_en), .apb_write(apb_write),
        .apb_addr(apb_addr), .apb_wdata(apb_wdata), .apb_rdata(apb_rdata),
        .apb_ready(apb_ready), .apb_slverr(apb_slverr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- slave model
    logic [DATA_W-1:0] slave_mem [256];
    logic [DATA_W-1:0] model_mem [256];
    logic stall  = 1'b0;
    logic never1 = 1'b0;
    int   acc_n  = 0;

    always @(posedge apb_clk) acc_n <= (apb_selx && apb_en) ? acc_n + 1 : 0;

    assign apb_rdata  = slave_mem[apb_addr];
    assign apb_slverr = (apb_addr == 8'd100);
    assign apb_ready  = !stall && !(never1 && apb_addr == 8'd1) &&
                        !(apb_addr == 8'd2 && acc_n != 15);

    always @(posedge apb_clk) begin
        if (apb_selx && apb_en && apb_ready && apb_write && !apb_slverr)
            slave_mem[apb_addr] <= apb_wdata;
    end

    // ----------------------------------------------------------- scoreboard
    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic [1:0]        err;
        int                acclen;
        int                lat;
        int                tpush;
    } exp_t;

    exp_t sb[$];
    bit   lat_next    = 1'b0;
    int   acclen_next = -1;

    int   neg_cnt = 0, acc_start = 0, sel_cyc = 0;
    logic prev_en = 1'b0;

    always @(negedge apb_clk) begin
        exp_t e;
        neg_cnt++;
        if (apb_selx) sel_cyc++;
        if (apb_en && !prev_en) acc_start = neg_cnt;
        prev_en = apb_en;
        if (apb_en) check_eq("en_needs_sel", apb_selx, 1);
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check_eq("rsp_unexpected_sbsize", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check_eq("rsp_rdata", rsp_rdata, e.rdata);
                check_eq("rsp_err", rsp_err, e.err);
                if (e.acclen >= 0) check_eq("access_len", neg_cnt - acc_start, e.acclen);
                if (e.lat >= 0) check_eq("first_latency_ns", int'($time) - e.tpush, e.lat);
            end
        end
    end

    // One push attempt lasting one clock; called at posedge+1.
    task automatic try_push(input logic [7:0] a, input logic [31:0] d, input logic w, output bit ok);
        exp_t e;
        req_valid = 1'b1; req_addr = a; req_wdata = d; req_write = w;
        @(negedge apb_clk);
        ok = req_ready;
        @(posedge apb_clk);
        if (ok) begin
            e.tpush  = int'($time);
            e.lat    = lat_next ? 3*CLK_P + CLK_P/2 : -1;
            lat_next = 1'b0;
            e.acclen = acclen_next;
            acclen_next = -1;
            if (a == 8'd100) begin
                e.rdata = '0; e.err = 2'b01;
`ifdef APB_MASTER_Q_TIMEOUT_EN
            end else if (a == 8'd1 && never1) begin
                e.rdata = '0; e.err = 2'b10;
`endif
            end else if (w) begin
                e.rdata = '0; e.err = 2'b00;
                model_mem[a] = d;
            end else begin
                e.rdata = model_mem[a]; e.err = 2'b00;
            end
            sb.push_back(e);
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic push_req(input logic [7:0] a, input logic [31:0] d, input logic w);
        bit ok = 1'b0;
        int unsigned n = 0;
        while (!ok && n < 100) begin
            try_push(a, d, w, ok);
            n++;
        end
        if (!ok) check_eq("push_accept", ok, 1);
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge apb_clk);
            n++;
        end
        check_eq(tag, sb.size(), 0);
        @(posedge apb_clk);
        #1;
    endtask

    initial begin
        #(CLK_P * 20000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------- stimulus
    initial begin
        bit ok;
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = 32'(i * 3 + 7);
            model_mem[i] = 32'(i * 3 + 7);
        end
        apb_reset = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
        repeat (2) @(posedge apb_clk);
        @(negedge apb_clk);
        check_eq("reset_req_ready", req_ready, 1);
        check_eq("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        check_eq("reset_level", fifo_level, 0);
        check_eq("reset_apb", {apb_selx, apb_en, apb_write, apb_addr, apb_wdata}, 0);
        apb_reset = 1'b1;
        @(posedge apb_clk); #1;

        // Write then read back, zero-wait, back-to-back.
        sel_cyc  = 0;
        lat_next = 1'b1;
        push_req(8'd4, 32'd10, 1'b1);
        push_req(8'd5, 32'd12, 1'b1);
        push_req(8'd4, 32'd0, 1'b0);
        push_req(8'd5, 32'd0, 1'b0);
        wait_drain("drain_wr_rd");
        check_eq("b2b_selx_cycles", sel_cyc, 8);

        // FIFO full with the slave stalled.
        stall = 1'b1;
        try_push(8'd20, 32'hAA, 1'b1, ok); check_eq("full_acc0", ok, 1);
        try_push(8'd21, 32'hBB, 1'b1, ok); check_eq("full_acc1", ok, 1);
        try_push(8'd20, 32'd0, 1'b0, ok);  check_eq("full_acc2", ok, 1);
        try_push(8'd21, 32'd0, 1'b0, ok);  check_eq("full_acc3", ok, 1);
        try_push(8'd5, 32'd0, 1'b0, ok);   check_eq("full_acc4", ok, 1);
        check_eq("full_level", fifo_level, 4);
        check_eq("full_req_ready", req_ready, 0);
        try_push(8'd22, 32'hCC, 1'b1, ok); check_eq("full_blocked", ok, 0);
        check_eq("full_level_hold", fifo_level, 4);
        stall = 1'b0;
        wait_drain("drain_full");

        // Slave error on read and write.
        push_req(8'd100, 32'd0, 1'b0);
        push_req(8'd100, 32'h55, 1'b1);
        wait_drain("drain_slverr");

        // Ready arrives in the 16th ACCESS cycle.
        acclen_next = 16;
        push_req(8'd2, 32'd0, 1'b0);
        wait_drain("drain_late_ready");

`ifdef APB_MASTER_Q_TIMEOUT_EN
        // Timeout abort followed by a normal transfer.
        never1      = 1'b1;
        acclen_next = 16;
        push_req(8'd1, 32'd0, 1'b0);
        push_req(8'd5, 32'd0, 1'b0);
        wait_drain("drain_timeout");
        never1 = 1'b0;
`endif

        // Reset during ACCESS with two entries queued.
        stall = 1'b1;
        try_push(8'd4, 32'd0, 1'b0, ok);   check_eq("rst_acc0", ok, 1);
        try_push(8'd5, 32'd0, 1'b0, ok);   check_eq("rst_acc1", ok, 1);
        try_push(8'd21, 32'd0, 1'b0, ok);  check_eq("rst_acc2", ok, 1);
        begin
            int unsigned n = 0;
            while (!apb_en && n < 20) begin
                @(negedge apb_clk);
                n++;
            end
        end
        check_eq("rst_in_access", apb_en, 1);
        check_eq("rst_queued", fifo_level, 2);
        #2 apb_reset = 1'b0;
        #1;
        sb.delete();
        check_eq("rst_async_apb", {apb_selx, apb_en, apb_write, apb_addr, apb_wdata}, 0);
        check_eq("rst_async_level", fifo_level, 0);
        check_eq("rst_async_ready", req_ready, 1);
        check_eq("rst_async_rsp", rsp_valid, 0);
        repeat (2) @(negedge apb_clk);
        apb_reset = 1'b1;
        stall = 1'b0;
        repeat (5) @(posedge apb_clk);
        #1;
        check_eq("post_rst_level", fifo_level, 0);
        check_eq("post_rst_selx", apb_selx, 0);
        push_req(8'd4, 32'd0, 1'b0);
        wait_drain("drain_post_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
